// File: rtl/pri_ctrl_pkg.sv
// Shared types and sizes for the TC0360PRI register front-end.
package pri_ctrl_pkg;

  localparam int PRI_NUM_REGS = 16;
  localparam int PRI_ADDR_W   = 4;

  typedef logic [7:0] pri_reg_t;

  typedef enum logic [1:0] {
    PC_IDLE,
    PC_COPY,
    PC_DONE
  } pri_commit_state_t;

endpackage

// File: rtl/pri_commit_sequencer_if.sv
// CPU register bus for the priority mixer front-end.
interface pri_commit_sequencer_if;
  import pri_ctrl_pkg::*;

  logic                  cs;
  logic                  cpu_rw;
  logic [PRI_ADDR_W-1:0] cpu_addr;
  logic [1:0]            cpu_ds_n;
  pri_reg_t              cpu_din;
  pri_reg_t              cpu_dout;

  modport master (output cs, cpu_rw, cpu_addr, cpu_ds_n, cpu_din, input cpu_dout);
  modport slave  (input cs, cpu_rw, cpu_addr, cpu_ds_n, cpu_din, output cpu_dout);

endinterface

// File: rtl/pri_rise_detect.sv
// Rising-edge detector: one-cycle pulse when a level input goes 0->1.
module pri_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_d, in_q;

  always_comb in_d = in;

  always_ff @(posedge clk) begin
    if (reset) in_q <= 1'b0;
    else       in_q <= in_d;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/pri_commit_sequencer.sv
// Double-buffered mixer control bank; shadow->live copy runs once per vblank rise.
// Build option PRI_VBLANK_LATCH_EN enables the vblank-latched copy; otherwise writes go live at once.
module pri_commit_sequencer
  import pri_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  pri_commit_sequencer_if.slave     cpu,
  input  logic                      vblank,
  output logic [8*PRI_NUM_REGS-1:0] ctrl_live,
  output logic                      busy,
  output logic                      commit_done
);

  pri_reg_t                 shadow_q [PRI_NUM_REGS];
  pri_reg_t                 shadow_d [PRI_NUM_REGS];
  pri_reg_t                 live_q   [PRI_NUM_REGS];
  pri_reg_t                 live_d   [PRI_NUM_REGS];
  logic [PRI_NUM_REGS-1:0]  dirty_q, dirty_d;
  pri_reg_t                 cpu_dout_q, cpu_dout_d;
  pri_commit_state_t        state_q, state_d;
  logic [PRI_ADDR_W-1:0]    idx_q, idx_d;
  logic                     pending_q, pending_d;
  logic                     busy_q, busy_d;
  logic                     commit_done_q, commit_done_d;

  logic wr_en, rd_en;
  assign wr_en = cpu.cs & ~cpu.cpu_rw & ~cpu.cpu_ds_n[0];
  assign rd_en = cpu.cs &  cpu.cpu_rw;

`ifdef PRI_VBLANK_LATCH_EN
  logic rise;
  logic unused_ok;
  assign unused_ok = cpu.cpu_ds_n[1];

  pri_rise_detect u_vblank_rise (
    .clk   (clk),
    .reset (reset),
    .in    (vblank),
    .rise  (rise)
  );
`else
  logic unused_ok;
  assign unused_ok = ^{cpu.cpu_ds_n[1], vblank};
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches);
    // blocking '=' is correct here, only the always_ff uses '<='.
    shadow_d      = shadow_q;
    live_d        = live_q;
    dirty_d       = dirty_q;
    state_d       = state_q;
    idx_d         = idx_q;
    pending_d     = pending_q;
    cpu_dout_d    = rd_en ? shadow_q[cpu.cpu_addr] : cpu_dout_q;

`ifdef PRI_VBLANK_LATCH_EN
    unique case (state_q)
      PC_IDLE: begin
        if (rise) begin
          state_d = PC_COPY;
          idx_d   = '0;
        end
      end
      PC_COPY: begin
        if (rise) pending_d = 1'b1;
        if (dirty_q[idx_q]) begin
          live_d[idx_q]  = shadow_q[idx_q];
          dirty_d[idx_q] = 1'b0;
        end
        if (idx_q == PRI_ADDR_W'(PRI_NUM_REGS - 1)) state_d = PC_DONE;
        else                                        idx_d   = idx_q + 1'b1;
      end
      PC_DONE: begin
        // A rise landing in the DONE cycle itself also earns another pass.
        if (pending_q | rise) begin
          pending_d = 1'b0;
          state_d   = PC_COPY;
          idx_d     = '0;
        end else begin
          state_d   = PC_IDLE;
        end
      end
      default: state_d = PC_IDLE;
    endcase

    // Applied after the copy so a same-index write keeps its dirty bit.
    if (wr_en) begin
      shadow_d[cpu.cpu_addr] = cpu.cpu_din;
      dirty_d[cpu.cpu_addr]  = 1'b1;
    end
`else
    if (wr_en) begin
      shadow_d[cpu.cpu_addr] = cpu.cpu_din;
      live_d[cpu.cpu_addr]   = cpu.cpu_din;
    end
`endif

    busy_d        = (state_d == PC_COPY);
    commit_done_d = (state_d == PC_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register banks are reset explicitly; the mixer must see all-zero controls.
      shadow_q      <= '{default: '0};
      live_q        <= '{default: '0};
      dirty_q       <= '0;
      cpu_dout_q    <= '0;
      state_q       <= PC_IDLE;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      busy_q        <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      live_q        <= live_d;
      dirty_q       <= dirty_d;
      cpu_dout_q    <= cpu_dout_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
      commit_done_q <= commit_done_d;
    end
  end

  for (genvar i = 0; i < PRI_NUM_REGS; i++) begin : g_live_flat
    assign ctrl_live[8*i +: 8] = live_q[i];
  end

  assign cpu.cpu_dout = cpu_dout_q;
  assign busy         = busy_q;
  assign commit_done  = commit_done_q;

endmodule

// File: tb/tb_pri_commit_sequencer.sv
// Randomized + directed bench for pri_commit_sequencer against a register-bank reference model.
module tb_pri_commit_sequencer;
  import pri_ctrl_pkg::*;

`ifdef PRI_VBLANK_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         vblank;
  logic [127:0] ctrl_live;
  logic         busy;
  logic         commit_done;

  pri_commit_sequencer_if bus ();

  pri_commit_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .cpu         (bus),
    .vblank      (vblank),
    .ctrl_live   (ctrl_live),
    .busy        (busy),
    .commit_done (commit_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the register banks plus a commit-pass position
  // (-1 = no pass running, 0..15 = register being committed, 16 = pass just finished).
  logic [7:0] m_shadow [16];
  logic [7:0] m_live   [16];
  bit         m_dirty  [16];
  logic [7:0] m_dout;
  int         m_pos;
  bit         m_pend;
  bit         m_vb_prev;

  task automatic model_step();
    bit rise;
    bit wr;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_shadow[i] = 8'h00; m_live[i] = 8'h00; m_dirty[i] = 1'b0;
      end
      m_dout = 8'h00; m_pos = -1; m_pend = 1'b0; m_vb_prev = 1'b0;
      return;
    end
    rise      = vblank && !m_vb_prev;
    m_vb_prev = vblank;
    wr        = bus.cs && !bus.cpu_rw && !bus.cpu_ds_n[0];
    if (bus.cs && bus.cpu_rw) m_dout = m_shadow[bus.cpu_addr];
    if (LATCH) begin
      if (m_pos >= 0 && m_pos < 16) begin
        if (m_dirty[m_pos]) begin
          m_live[m_pos]  = m_shadow[m_pos];
          m_dirty[m_pos] = 1'b0;
        end
        if (rise) m_pend = 1'b1;
        m_pos++;
      end else if (m_pos == 16) begin
        if (m_pend || rise) begin m_pend = 1'b0; m_pos = 0; end
        else m_pos = -1;
      end else if (rise) begin
        m_pos = 0;
      end
      if (wr) begin
        m_shadow[bus.cpu_addr] = bus.cpu_din;
        m_dirty[bus.cpu_addr]  = 1'b1;
      end
    end else if (wr) begin
      m_shadow[bus.cpu_addr] = bus.cpu_din;
      m_live[bus.cpu_addr]   = bus.cpu_din;
    end
  endtask

  function automatic logic [127:0] model_live();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = m_live[i];
    return v;
  endfunction

  // One clock: model follows the edge, DUT outputs compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("ctrl_live",   ctrl_live,     model_live());
    check("busy",        busy,          (LATCH && m_pos >= 0 && m_pos < 16));
    check("commit_done", commit_done,   (LATCH && m_pos == 16));
    check("cpu_dout",    bus.cpu_dout,  m_dout);
  endtask

  task automatic idle_bus();
    bus.cs = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_addr = '0; bus.cpu_ds_n = 2'b11; bus.cpu_din = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [1:0] ds);
    bus.cs = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = a; bus.cpu_ds_n = ds; bus.cpu_din = d;
    cycle();
    idle_bus();
  endtask

  task automatic rd(input logic [3:0] a);
    bus.cs = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = a;
    cycle();
    idle_bus();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic vb_pulse();
    vblank = 1'b1;
    cycle();
    vblank = 1'b0;
  endtask

  int busy_cnt, done_cnt;

  initial begin
    idle_bus();
    vblank = 1'b0;
    reset  = 1'b1;
    idle(2);
    check("reset_live", ctrl_live, 128'h0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;

    // Shadow write stays out of the live bank until a commit.
    wr(4'd4, 8'h21, 2'b10);
    check("live4_pre", ctrl_live[39:32], LATCH ? 8'h00 : 8'h21);
    rd(4'd4);
    check("rd4", bus.cpu_dout, 8'h21);

    // Commit of regs 4,5: 16 busy cycles then one done pulse.
    wr(4'd5, 8'h43, 2'b10);
    vb_pulse();
    busy_cnt = busy ? 1 : 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      busy_cnt += busy ? 1 : 0;
      done_cnt += commit_done ? 1 : 0;
    end
    check("busy_len", busy_cnt, LATCH ? 16 : 0);
    check("done_cnt", done_cnt, LATCH ? 1 : 0);
    check("live45", ctrl_live[47:32], 16'h4321);

    // Same-index write during the copy of idx 7.
    wr(4'd7, 8'h11, 2'b10);
    vb_pulse(); idle(20);
    wr(4'd7, 8'h22, 2'b10);
    vb_pulse(); idle(7);
    wr(4'd7, 8'h55, 2'b10);
    idle(12);
    check("collide_live7", ctrl_live[63:56], LATCH ? 8'h22 : 8'h55);
    vb_pulse(); idle(20);
    check("next_live7", ctrl_live[63:56], 8'h55);

    // Three rises inside one pass collapse into exactly one extra pass.
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      vblank = (i == 0 || i == 4 || i == 8);
      cycle();
      busy_cnt += busy ? 1 : 0;
      done_cnt += commit_done ? 1 : 0;
    end
    vblank = 1'b0;
    check("double_busy", busy_cnt, LATCH ? 32 : 0);
    check("double_done", done_cnt, LATCH ? 2 : 0);

    // Reset while copying idx 8 discards the partial commit.
    for (int i = 0; i < 16; i++) wr(4'(i), 8'(8'hA0 + i), 2'b10);
    vb_pulse(); idle(8);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_live", ctrl_live, 128'h0);

    // Low strobe deasserted: write has no effect on shadow or on a later commit.
    wr(4'd3, 8'hAA, 2'b01);
    rd(4'd3);
    check("ds_rd3", bus.cpu_dout, 8'h00);
    vb_pulse(); idle(20);
    check("ds_live3", ctrl_live[31:24], 8'h00);

    // Randomized traffic with sparse vblank toggles and rare resets.
    for (int n = 0; n < 3000; n++) begin
      bus.cs       = ($urandom_range(0, 2) != 0);
      bus.cpu_rw   = $urandom_range(0, 1);
      bus.cpu_addr = 4'($urandom_range(0, 15));
      bus.cpu_ds_n = 2'($urandom_range(0, 3));
      bus.cpu_din  = 8'($urandom);
      if ($urandom_range(0, 14) == 0) vblank = ~vblank;
      reset = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0;
    idle_bus();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
